// File: rtl/overture_pkg.sv
// Shared types and constants for the OVERTURE decode stage.
// Instruction byte layout: ir[7:6] opcode, ir[5:3] source code, ir[2:0]
// destination code / ALU op / condition code.
package overture_pkg;

    localparam int OVT_REG_COUNT  = 6;
    localparam int OVT_DATA_WIDTH = 8;

    // Register-code values above the general registers.
    localparam logic [2:0] CODE_IO   = 3'd6;
    localparam logic [2:0] CODE_RSVD = 3'd7;

    typedef enum logic [1:0] {
        OP_IMM  = 2'b00,
        OP_ALU  = 2'b01,
        OP_COPY = 2'b10,
        OP_COND = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NEVER  = 3'd0,
        CC_EQ     = 3'd1,
        CC_LT     = 3'd2,
        CC_LE     = 3'd3,
        CC_ALWAYS = 3'd4,
        CC_NE     = 3'd5,
        CC_GE     = 3'd6,
        CC_GT     = 3'd7
    } cond_code_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // True when a 3-bit code addresses one of the general registers.
    function automatic logic is_reg_code(input logic [2:0] code);
        return (code < CODE_IO);
    endfunction

endpackage

// File: rtl/overture_cond_eval.sv
// Combinational condition evaluator: decides whether a COND instruction
// jumps, given the signed reg3 value and the 3-bit condition code.
module overture_cond_eval
    import overture_pkg::*;
#(
    parameter int DATA_WIDTH = OVT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] cond_value,
    input  logic [2:0]            cc,
    output logic                  take
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (cond_value == '0);
    assign is_neg  = cond_value[DATA_WIDTH-1];

    // Map the condition code onto zero/sign flags of the two's complement value.
    always_comb begin
        take = 1'b0;
        case (cond_code_t'(cc))
            CC_NEVER:  take = 1'b0;
            CC_EQ:     take = is_zero;
            CC_LT:     take = is_neg;
            CC_LE:     take = is_neg | is_zero;
            CC_ALWAYS: take = 1'b1;
            CC_NE:     take = ~is_zero;
            CC_GE:     take = ~is_neg;
            CC_GT:     take = ~is_neg & ~is_zero;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_decode_stage.sv
// OVERTURE fetch/decode/sequencing stage. Fetches one instruction byte,
// then spends exactly one EXEC cycle driving one-hot bus strobes decoded
// from the instruction register, and updates the program counter.
// Optional feature macro: OVERTURE_SINGLE_STEP_EN adds step/halted ports and
// a HALT state entered after every instruction.
module overture_decode_stage
    import overture_pkg::*;
#(
    parameter int REG_COUNT  = OVT_REG_COUNT,
    parameter int DATA_WIDTH = OVT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    // Program fetch handshake: prog_addr is always the PC; while in FETCH the
    // stage captures prog_data on any rising edge where prog_valid is high and
    // otherwise simply waits (there is no back-pressure signal to memory).
    output logic [DATA_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic                  prog_valid,
    input  logic [DATA_WIDTH-1:0] cond_value,
    input  logic [DATA_WIDTH-1:0] jump_target,
    output logic [REG_COUNT-1:0]  reg_save,
    output logic [REG_COUNT-1:0]  reg_oe,
    output logic                  in_oe,
    output logic                  out_save,
    output logic                  imm_oe,
    output logic [DATA_WIDTH-1:0] imm_value,
    output logic                  alu_oe,
    output logic [2:0]            alu_op,
    output logic                  illegal_op,
`ifdef OVERTURE_SINGLE_STEP_EN
    input  logic                  step,
    output logic                  halted,
`endif
    output logic [1:0]            state_dbg
);

    localparam logic [REG_COUNT-1:0] ONE_HOT_0 = {{(REG_COUNT-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;

    opcode_t    opcode;
    logic [2:0] src_code;
    logic [2:0] dst_code;
    logic       take;

    assign opcode   = opcode_t'(ir_q[7:6]);
    assign src_code = ir_q[5:3];
    assign dst_code = ir_q[2:0];

    assign prog_addr = pc_q;
    assign imm_value = {{(DATA_WIDTH-6){1'b0}}, ir_q[5:0]};
    assign state_dbg = state_q;

`ifdef OVERTURE_SINGLE_STEP_EN
    assign halted = (state_q == HALT);
`endif

    overture_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond_eval (
        .cond_value (cond_value),
        .cc         (dst_code),
        .take       (take)
    );

    // State, PC and instruction registers; reset drops every strobe at once
    // because all strobes are gated by state_q == EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, instruction capture and end-of-EXEC PC update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                if (prog_valid) begin
                    ir_d    = prog_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (opcode == OP_COND && take) begin
                    pc_d = jump_target;
                end else begin
                    pc_d = pc_q + DATA_WIDTH'(1);
                end
`ifdef OVERTURE_SINGLE_STEP_EN
                state_d = HALT;
`else
                state_d = FETCH;
`endif
            end
`ifdef OVERTURE_SINGLE_STEP_EN
            HALT: begin
                if (step) begin
                    state_d = FETCH;
                end
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // Strobe decode: active only during EXEC, at most one driver and one saver.
    always_comb begin
        reg_save   = '0;
        reg_oe     = '0;
        in_oe      = 1'b0;
        out_save   = 1'b0;
        imm_oe     = 1'b0;
        alu_oe     = 1'b0;
        alu_op     = 3'd0;
        illegal_op = 1'b0;
        if (state_q == EXEC) begin
            case (opcode)
                OP_IMM: begin
                    imm_oe   = 1'b1;
                    reg_save = ONE_HOT_0;
                end
                OP_ALU: begin
                    alu_oe   = 1'b1;
                    alu_op   = dst_code;
                    reg_save = ONE_HOT_0 << 3;
                end
                OP_COPY: begin
                    // A reserved code on either side suppresses the whole move.
                    if (src_code == CODE_RSVD || dst_code == CODE_RSVD) begin
                        illegal_op = 1'b1;
                    end else begin
                        if (is_reg_code(src_code)) begin
                            reg_oe = ONE_HOT_0 << src_code;
                        end else begin
                            in_oe = 1'b1;
                        end
                        if (is_reg_code(dst_code)) begin
                            reg_save = ONE_HOT_0 << dst_code;
                        end else begin
                            out_save = 1'b1;
                        end
                    end
                end
                default: begin
                    // COND only affects the PC; nothing touches the bus.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_overture_decode_stage.sv
// Self-checking bench for overture_decode_stage. A driver issues instruction
// bytes and pushes the expected strobe pattern and next PC into a queue; a
// monitor pops an entry whenever the stage is executing and compares.
module tb_overture_decode_stage;
    import overture_pkg::*;

    localparam int W = 36; // {next_pc[8], imm[8], strobes[20]}

    logic       clk;
    logic       rst;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_valid;
    logic [7:0] cond_value;
    logic [7:0] jump_target;
    logic [5:0] reg_save;
    logic [5:0] reg_oe;
    logic       in_oe;
    logic       out_save;
    logic       imm_oe;
    logic [7:0] imm_value;
    logic       alu_oe;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic [1:0] state_dbg;
`ifdef OVERTURE_SINGLE_STEP_EN
    logic       step;
    logic       halted;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   model_pc;

    logic [19:0] act_vec;
    assign act_vec = {reg_save, reg_oe, in_oe, out_save, imm_oe, alu_oe, alu_op, illegal_op};

    overture_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_valid  (prog_valid),
        .cond_value  (cond_value),
        .jump_target (jump_target),
        .reg_save    (reg_save),
        .reg_oe      (reg_oe),
        .in_oe       (in_oe),
        .out_save    (out_save),
        .imm_oe      (imm_oe),
        .imm_value   (imm_value),
        .alu_oe      (alu_oe),
        .alu_op      (alu_op),
        .illegal_op  (illegal_op),
`ifdef OVERTURE_SINGLE_STEP_EN
        .step        (step),
        .halted      (halted),
`endif
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: behaviour of one instruction from the ISA rules.
    function automatic logic [W-1:0] model(input logic [7:0] ins, input logic [7:0] cv,
                                           input logic [7:0] jt, input logic [7:0] pc);
        logic [5:0] rs, ro;
        logic       ino, outs, immoe, aluoe, ill, take;
        logic [2:0] aop;
        logic [7:0] imm, npc;
        int c, src, dst;
        rs = '0; ro = '0; ino = 0; outs = 0; immoe = 0; aluoe = 0; ill = 0; take = 0;
        aop = '0; imm = '0;
        c   = $signed(cv);
        src = int'(ins[5:3]);
        dst = int'(ins[2:0]);
        case (ins[7:6])
            2'b00: begin immoe = 1; rs[0] = 1; imm = {2'b00, ins[5:0]}; end
            2'b01: begin aluoe = 1; aop = ins[2:0]; rs[3] = 1; end
            2'b10: begin
                if (src == 7 || dst == 7) ill = 1;
                else begin
                    if (src == 6) ino = 1; else ro[src] = 1;
                    if (dst == 6) outs = 1; else rs[dst] = 1;
                end
            end
            default: begin
                case (dst)
                    0: take = 0;
                    1: take = (c == 0);
                    2: take = (c < 0);
                    3: take = (c <= 0);
                    4: take = 1;
                    5: take = (c != 0);
                    6: take = (c >= 0);
                    default: take = (c > 0);
                endcase
            end
        endcase
        npc = take ? jt : 8'((int'(pc) + 1) % 256);
        return {npc, imm, rs, ro, ino, outs, immoe, aluoe, aop, ill};
    endfunction

    // Driver: optional wait cycles with garbage data, then one valid byte.
    task automatic issue(input logic [7:0] ins, input int waits, input logic [7:0] cv, input logic [7:0] jt);
        logic [W-1:0] e;
        cond_value  = cv;
        jump_target = jt;
        e = model(ins, cv, jt, model_pc);
        model_pc = e[35:28];
        exp_q.push_back(e);
        for (int i = 0; i < waits; i++) begin
            prog_valid = 1'b0;
            prog_data  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        prog_valid = 1'b1;
        prog_data  = ins;
        @(posedge clk); #1;
        prog_valid = 1'b0;
        prog_data  = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
`ifdef OVERTURE_SINGLE_STEP_EN
        check("halted_set", 64'(halted), 64'd1);
        @(posedge clk); #1;
        check("halted_hold", 64'(halted), 64'd1);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        check("halted_clear", 64'(halted), 64'd0);
`endif
    endtask

    // Monitor: compare strobes in EXEC, the following PC, and idle quiet.
    logic       pc_pend = 1'b0;
    logic [7:0] pc_exp;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            pc_pend = 1'b0;
        end else begin
            if (pc_pend) begin
                check("next_pc", 64'(prog_addr), 64'(pc_exp));
                pc_pend = 1'b0;
            end
            if (state_dbg == EXEC) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_exec", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("strobes", 64'(act_vec), 64'(e[19:0]));
                    if (e[5]) check("imm_value", 64'(imm_value), 64'(e[27:20]));
                    pc_exp  = e[35:28];
                    pc_pend = 1'b1;
                end
            end else begin
                check("idle_strobes", 64'(act_vec), 64'd0);
            end
        end
    end

    logic [7:0] cvals [5] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};

    initial begin
        rst = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        cond_value = 8'h00; jump_target = 8'h00; model_pc = 8'h00;
`ifdef OVERTURE_SINGLE_STEP_EN
        step = 1'b0;
`endif
        #3;
        check("reset_prog_addr", 64'(prog_addr), 64'd0);
        check("reset_strobes", 64'(act_vec), 64'd0);
        check("reset_imm_value", 64'(imm_value), 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed instructions
        issue(8'h05, 0, 8'h00, 8'h00);
        issue(8'h8B, 3, 8'h00, 8'h00);
        issue(8'hB1, 0, 8'h00, 8'h00);
        issue(8'h8E, 1, 8'h00, 8'h00);
        issue(8'hBF, 0, 8'h00, 8'h00);
        issue(8'h92, 0, 8'h00, 8'h00); // self-copy r2->r2
        issue(8'h45, 0, 8'h00, 8'h00);

        // Condition sweep
        foreach (cvals[k])
            for (int cc = 0; cc < 8; cc++)
                issue({5'b11000, 3'(cc)}, 0, cvals[k], 8'h40);

        // PC wrap and jump at 8'hFF
        issue(8'hC4, 0, 8'h00, 8'hFF);
        issue(8'h01, 0, 8'h00, 8'h00);
        issue(8'hC4, 0, 8'h00, 8'hFF);
        issue(8'hC4, 0, 8'h00, 8'h40);

        // Reset in the middle of an ALU EXEC cycle
        repeat (2) @(posedge clk); #1;
        prog_data = 8'h44; prog_valid = 1'b1;
        @(posedge clk); #1;
        prog_valid = 1'b0;
        check("pre_rst_alu_oe", 64'(alu_oe), 64'd1);
        check("pre_rst_reg_save", 64'(reg_save), 64'h08);
        #1 rst = 1'b0;
        #1;
        check("rst_alu_oe_drop", 64'(alu_oe), 64'd0);
        check("rst_reg_save_drop", 64'(reg_save), 64'd0);
        check("rst_prog_addr", 64'(prog_addr), 64'd0);
        model_pc = 8'h00;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        issue(8'h2A, 0, 8'h00, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 150; n++)
            issue(8'($urandom_range(0, 255)), $urandom_range(0, 2),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        repeat (4) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
